vote_tally: RTL
===============

# vote_tally

Parametrised, sequential successor to the 5-input combinational voter: samples an N-bit vote vector on request and waits until the vector has been stable for HOLD cycles. It then registers the popcount and a pass/fail decision against a programmable threshold. It sits between raw, possibly bouncing, voter inputs and downstream control logic that needs a clean, debounced majority decision with a one-cycle valid strobe.

## Interface
- N, 5, number of voter inputs (≥1)
- THRESH, (N/2)+1, minimum number of set votes for pass (1 ≤ THRESH ≤ N)
- HOLD, 4, consecutive stable cycles required before a decision (≥1)
- TMO, 64, maximum SETTLE cycles before abort (TMO > HOLD)
- CW, $clog2(N+1), width of count (derived localparam)

Ports:
- clk  in  1  single clock; all state on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a vote; sampled in IDLE only
- vote_in  in  N  raw vote vector, bit i = voter i
- busy  out  1  high in SETTLE and DECIDE
- valid  out  1  one-cycle strobe: new count and F are present
- err  out  1  one-cycle strobe: timeout, no decision made
- count  out  CW  number of set bits in the decided vector
- F  out  1  pass flag: count ≥ THRESH

## Operation
- States are IDLE, SETTLE and DECIDE.
- **IDLE:** on start=1, capture vote_in into snap, clear stab and tmr, then go to SETTLE. Otherwise remain in IDLE.
- **SETTLE:** every edge, tmr increments.
  - If vote_in ≠ snap: reload snap and clear stab.
  - Else: stab increments.
  - When stab reaches HOLD, go to DECIDE.
  - When tmr reaches TMO without stability: pulse err, go to IDLE. count and F are not updated.
- **DECIDE:** register count = popcount(snap) and F = (popcount ≥ THRESH). Pulse valid and go to IDLE.
- Simultaneous events: if stability and the timeout occur on the same edge, stability wins (no err).
- start is ignored while busy. start held high in IDLE begins a new vote on every return to IDLE.
- count and F hold their last decided values until the next DECIDE.
- Arithmetic: popcount is an unsigned sum, exact over the range 0..N. The comparison is unsigned. stab and tmr saturate and never wrap.

## Timing
- Reset values: busy=0, valid=0, err=0, count=0, F=0, state=IDLE, snap=0, stab=0, tmr=0.
- Reset asserted mid-operation aborts immediately and asynchronously. No valid or err is produced for the aborted vote.
- Latency with a constant vote_in:
  - The start edge is edge 0.
  - Edges 1..HOLD are stable compares; the FSM enters DECIDE after edge HOLD.
  - valid, count and F update at edge HOLD+1, i.e. HOLD+1 edges after start.
- Each vote_in change during SETTLE restarts the HOLD window.
- err asserts at the TMO-th edge after entering SETTLE.
- valid and err are mutually exclusive and each is exactly one cycle wide.
- busy rises the cycle after the start edge and falls in the same cycle that valid or err is high.
- The earliest next start is accepted on the edge after valid or err.

## Configuration
- **VOTE_TALLY_VETO_EN defined:**
  - Adds input veto (1 bit). veto=1 on any edge during SETTLE or DECIDE forces the decided F=0; count is still the true popcount.
  - Adds output veto_seen (1 bit), registered with valid: 1 if a veto occurred during that vote, 0 otherwise. Reset value is 0.
  - veto in IDLE is ignored.
- **Macro undefined:** no veto or veto_seen ports; F depends on the threshold alone.

## Test plan
(N=5, THRESH=3, HOLD=4, TMO=16)
- **Reset:** hold rst=1 with random vote_in/start → all outputs 0; after release, busy stays 0 until start.
- **Majority sweep:** vote_in 00001, 00011, 00111, 01111, 11111, each with a start pulse and held constant. Expected count 1, 2, 3, 4, 5 and F 0, 0, 1, 1, 1. valid arrives exactly 5 edges after each start.
- **Bounce:** start with 00111, change to 00110 at edge 2, then hold → valid at edge 7 with count=2, F=0.
- **Timeout:** toggle vote_in every 2 cycles after start → err pulse at the 16th SETTLE edge, no valid, and count/F keep their previous values.
- **Start while busy, then mid-op reset:** start pulses at edges 1–3 produce a single vote. Asserting rst at edge 3 of a later vote → no valid or err, outputs 0, and the next start works normally.
- **Veto (VOTE_TALLY_VETO_EN):** vote_in 11111 with veto pulsed at edge 2 → count=5, F=0, veto_seen=1. A repeat without veto gives F=1, veto_seen=0.

Source files
------------

// File: rtl/vote_tally.sv
// rtl/vote_tally.sv - debounced N-input majority voter with stability window and timeout
//
// Purpose: on start, tracks vote_in until it has held one value for HOLD
// consecutive edges, then registers its popcount and a pass flag against
// THRESH with a one-cycle valid strobe. If stability is not reached within
// TMO edges, a one-cycle err strobe is produced instead.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      request a vote (accepted in IDLE only)
//   vote_in    raw vote vector, bit i = voter i
//   busy       high while a vote is settling or being decided
//   valid      one-cycle strobe: count and F just updated
//   err        one-cycle strobe: vote abandoned on timeout
//   count      popcount of the last decided vector
//   F          pass flag of the last decided vector (count >= THRESH)
//
// Optional feature macro: VOTE_TALLY_VETO_EN
//   veto       input; any assertion during SETTLE/DECIDE forces the decided F to 0
//   veto_seen  output; updated with valid, 1 if the decided vote saw a veto
module vote_tally #(
  parameter int N      = 5,
  parameter int THRESH = (N / 2) + 1,
  parameter int HOLD   = 4,
  parameter int TMO    = 64,
  localparam int CW    = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  vote_in,
`ifdef VOTE_TALLY_VETO_EN
  input  logic          veto,
  output logic          veto_seen,
`endif
  output logic          busy,
  output logic          valid,
  output logic          err,
  output logic [CW-1:0] count,
  output logic          F
);

  localparam int SW = $clog2(HOLD + 1);
  localparam int TW = $clog2(TMO + 1);
  localparam logic [SW-1:0] HOLD_V   = SW'(HOLD);
  localparam logic [TW-1:0] TMO_V    = TW'(TMO);
  localparam logic [CW-1:0] THRESH_V = CW'(THRESH);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DECIDE
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    snap_q, snap_d;
  logic [SW-1:0]   stab_q, stab_d, stab_inc;
  logic [TW-1:0]   tmr_q, tmr_d, tmr_inc;
  logic            valid_d, err_d, f_d;
  logic [CW-1:0]   count_d, pop;
  logic            stable_hit, veto_block;
`ifdef VOTE_TALLY_VETO_EN
  logic            veto_flag_q, veto_flag_d, veto_seen_d;
`endif

  // Counters stop at their terminal value; reaching it always leaves SETTLE,
  // so saturation only matters as a guard against wrap.
  assign stab_inc = (stab_q == HOLD_V) ? stab_q : stab_q + 1'b1;
  assign tmr_inc  = (tmr_q == TMO_V) ? tmr_q : tmr_q + 1'b1;

  // Stability is judged on the incremented count so the FSM leaves SETTLE on
  // the HOLD-th matching edge rather than one edge later.
  assign stable_hit = (vote_in == snap_q) && (stab_inc == HOLD_V);

`ifdef VOTE_TALLY_VETO_EN
  // A veto on the DECIDE edge itself still counts.
  assign veto_block = veto_flag_q | veto;
`else
  assign veto_block = 1'b0;
`endif

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + CW'(snap_q[i]);
    end
  end

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    stab_d  = stab_q;
    tmr_d   = tmr_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    count_d = count;
    f_d     = F;
`ifdef VOTE_TALLY_VETO_EN
    veto_flag_d = veto_flag_q;
    veto_seen_d = veto_seen;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d  = vote_in;
          stab_d  = '0;
          tmr_d   = '0;
          state_d = SETTLE;
`ifdef VOTE_TALLY_VETO_EN
          veto_flag_d = 1'b0;
`endif
        end
      end
      SETTLE: begin
        tmr_d = tmr_inc;
        if (vote_in != snap_q) begin
          snap_d = vote_in;
          stab_d = '0;
        end else begin
          stab_d = stab_inc;
        end
        // Stability takes priority over a timeout on the same edge.
        if (stable_hit) begin
          state_d = DECIDE;
        end else if (tmr_inc == TMO_V) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
`ifdef VOTE_TALLY_VETO_EN
        if (veto) veto_flag_d = 1'b1;
`endif
      end
      DECIDE: begin
        count_d = pop;
        f_d     = (pop >= THRESH_V) && !veto_block;
        valid_d = 1'b1;
        state_d = IDLE;
`ifdef VOTE_TALLY_VETO_EN
        veto_seen_d = veto_block;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      snap_q  <= '0;
      stab_q  <= '0;
      tmr_q   <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
      count   <= '0;
      F       <= 1'b0;
`ifdef VOTE_TALLY_VETO_EN
      veto_flag_q <= 1'b0;
      veto_seen   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      stab_q  <= stab_d;
      tmr_q   <= tmr_d;
      valid   <= valid_d;
      err     <= err_d;
      count   <= count_d;
      F       <= f_d;
`ifdef VOTE_TALLY_VETO_EN
      veto_flag_q <= veto_flag_d;
      veto_seen   <= veto_seen_d;
`endif
    end
  end

endmodule
